// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipelined MIPS datapath.
//   wbsel_t        : writeback-source select carried down the pipe (memToReg)
//   memwb_state_t  : MEM/WB stage run/halt state
//   memwb_fields_t : architectural contents of the MEM/WB latch, laid out for
//                    the default 32-bit word / 5-bit register address datapath
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int CPU_WORD_W  = 32;
  localparam int CPU_RADDR_W = 5;

  typedef enum logic [1:0] {
    WB_PORTO = 2'd0,
    WB_DMEM  = 2'd1,
    WB_LUI   = 2'd2,
    WB_PC4   = 2'd3
  } wbsel_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } memwb_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   regWr;
    logic [CPU_RADDR_W-1:0] wsel;
    logic [CPU_WORD_W-1:0]  wdat;
  } memwb_fields_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Bundle of every mem_wb_stage port.
//   modport stage : the view of the pipeline register itself
//   modport tb    : the view of whatever drives/observes the stage
// Perf counter signals exist only when MEM_WB_PERF_EN is defined.
// -----------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int WORD_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
);

  logic               CLK;
  logic               RST;
  logic               ihit;
  logic               dhit;
  logic               stall;
  logic               flush;
  logic               valid_in;
  logic               regWr_in;
  logic [RADDR_W-1:0] wsel_in;
  logic [1:0]         memToReg_in;
  logic               halt_in;
  logic [WORD_W-1:0]  dmemload_in;
  logic [WORD_W-1:0]  portO_in;
  logic [WORD_W-1:0]  luiValue_in;
  logic [WORD_W-1:0]  pc4_in;
  logic               valid_out;
  logic               WEN;
  logic [RADDR_W-1:0] wsel_out;
  logic [WORD_W-1:0]  wdat_out;
  logic               halt_out;
`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0]   perf_retired;
  logic [CNT_W-1:0]   perf_bubbles;
`endif

  modport stage (
    input  CLK, RST, ihit, dhit, stall, flush, valid_in, regWr_in, wsel_in,
           memToReg_in, halt_in, dmemload_in, portO_in, luiValue_in, pc4_in,
`ifdef MEM_WB_PERF_EN
    output perf_retired, perf_bubbles,
`endif
    output valid_out, WEN, wsel_out, wdat_out, halt_out
  );

  modport tb (
    output CLK, RST, ihit, dhit, stall, flush, valid_in, regWr_in, wsel_in,
           memToReg_in, halt_in, dmemload_in, portO_in, luiValue_in, pc4_in,
`ifdef MEM_WB_PERF_EN
    input  perf_retired, perf_bubbles,
`endif
    input  valid_out, WEN, wsel_out, wdat_out, halt_out
  );

endinterface

// File: rtl/wb_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
// Combinational 4:1 writeback-source selector.
//   sel_i      : wbsel_t source select
//   porto_i    : ALU / port output
//   dmem_i     : data memory load value
//   lui_i      : LUI immediate value
//   pc4_i      : PC+4 (link value)
//   wdat_o     : selected word
// -----------------------------------------------------------------------------
module wb_mux
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  wbsel_t            sel_i,
  input  logic [WORD_W-1:0] porto_i,
  input  logic [WORD_W-1:0] dmem_i,
  input  logic [WORD_W-1:0] lui_i,
  input  logic [WORD_W-1:0] pc4_i,
  output logic [WORD_W-1:0] wdat_o
);

  always_comb begin
    wdat_o = porto_i;
    unique case (sel_i)
      WB_PORTO: wdat_o = porto_i;
      WB_DMEM:  wdat_o = dmem_i;
      WB_LUI:   wdat_o = lui_i;
      WB_PC4:   wdat_o = pc4_i;
      default:  wdat_o = porto_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Parametrised MEM/WB pipeline register with valid bit, stall, flush and a
// sticky halt state. The writeback source is resolved before the register, so
// the register file sees one write word and a qualified write enable.
//
// Optional feature macro: MEM_WB_PERF_EN (adds perf_retired / perf_bubbles).
//
// Ports
//   CLK, RST            clock (rising edge), async active-high reset
//   ihit, dhit, stall   advance = (ihit | dhit) & ~stall
//   flush               load a bubble (wins over stall)
//   valid_in .. pc4_in  MEM-stage instruction fields and writeback candidates
//   valid_out           registered valid
//   WEN                 qualified register-file write enable
//   wsel_out, wdat_out  registered destination and write word
//   halt_out            sticky halt, cleared only by RST
//   perf_retired        valid instructions loaded (MEM_WB_PERF_EN)
//   perf_bubbles        bubbles loaded, incl. flushes (MEM_WB_PERF_EN)
// -----------------------------------------------------------------------------
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_in,
  input  logic               regWr_in,
  input  logic [RADDR_W-1:0] wsel_in,
  input  logic [1:0]         memToReg_in,
  input  logic               halt_in,
  input  logic [WORD_W-1:0]  dmemload_in,
  input  logic [WORD_W-1:0]  portO_in,
  input  logic [WORD_W-1:0]  luiValue_in,
  input  logic [WORD_W-1:0]  pc4_in,
`ifdef MEM_WB_PERF_EN
  output logic [CNT_W-1:0]   perf_retired,
  output logic [CNT_W-1:0]   perf_bubbles,
`endif
  output logic               valid_out,
  output logic               WEN,
  output logic [RADDR_W-1:0] wsel_out,
  output logic [WORD_W-1:0]  wdat_out,
  output logic               halt_out
);

  // Same layout as memwb_fields_t, sized by this instance's parameters.
  typedef struct packed {
    logic               valid;
    logic               regWr;
    logic [RADDR_W-1:0] wsel;
    logic [WORD_W-1:0]  wdat;
  } fields_t;

  memwb_state_t      state_q, state_d;
  fields_t           fields_q, fields_d;
  logic              wen_q, wen_d;
  logic              adv;
  logic [WORD_W-1:0] wdat_sel;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [CNT_W-1:0]  bubbles_q, bubbles_d;
`endif

  assign adv = (ihit | dhit) & ~stall;

  wb_mux #(
    .WORD_W (WORD_W)
  ) u_wb_mux (
    .sel_i   (wbsel_t'(memToReg_in)),
    .porto_i (portO_in),
    .dmem_i  (dmemload_in),
    .lui_i   (luiValue_in),
    .pc4_i   (pc4_in),
    .wdat_o  (wdat_sel)
  );

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    wen_d    = wen_q;
`ifdef MEM_WB_PERF_EN
    retired_d = retired_q;
    bubbles_d = bubbles_q;
`endif
    unique case (state_q)
      RUN: begin
        if (flush) begin
          fields_d = '0;
          wen_d    = 1'b0;
`ifdef MEM_WB_PERF_EN
          bubbles_d = bubbles_q + 1'b1;
`endif
        end else if (adv) begin
          fields_d.valid = valid_in;
          fields_d.regWr = regWr_in;
          fields_d.wsel  = wsel_in;
          fields_d.wdat  = wdat_sel;
          // Enable is precomputed so it can be forced low while halted
          // without disturbing the frozen architectural fields.
          wen_d = valid_in & regWr_in & (wsel_in != '0);
          if (valid_in && halt_in) begin
            state_d = HALTED;
          end
`ifdef MEM_WB_PERF_EN
          if (valid_in) begin
            retired_d = retired_q + 1'b1;
          end else begin
            bubbles_d = bubbles_q + 1'b1;
          end
`endif
        end
      end
      HALTED: begin
        // The halting instruction keeps its single WEN cycle; after that the
        // register file must never be written again.
        wen_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      fields_q <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      wen_q    <= wen_d;
    end
  end

`ifdef MEM_WB_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      retired_q <= '0;
      bubbles_q <= '0;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_bubbles = bubbles_q;
`endif

  assign valid_out = fields_q.valid;
  assign WEN       = wen_q;
  assign wsel_out  = fields_q.wsel;
  assign wdat_out  = fields_q.wdat;
  assign halt_out  = (state_q == HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Table-driven directed vectors, hand-written halt/reset/counter sequences and
// randomized stimulus checked against a transaction-level reference model.
// Counter width is 4 so wrap-around is reachable quickly.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int WW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  typedef struct {
    bit        ihit, dhit, stall, flush, valid, regwr, halt;
    bit [4:0]  wsel;
    bit [1:0]  mts;
    bit [31:0] dmem, porto, lui, pc4;
  } in_t;

  typedef struct {
    in_t       in;
    bit        e_valid, e_wen, e_halt;
    bit [4:0]  e_wsel;
    bit [31:0] e_wdat;
  } vec_t;

  mem_wb_stage_if #(.WORD_W(WW), .RADDR_W(RW), .CNT_W(CW)) bus ();

  mem_wb_stage #(.WORD_W(WW), .RADDR_W(RW), .CNT_W(CW)) dut (
    .CLK         (bus.CLK),
    .RST         (bus.RST),
    .ihit        (bus.ihit),
    .dhit        (bus.dhit),
    .stall       (bus.stall),
    .flush       (bus.flush),
    .valid_in    (bus.valid_in),
    .regWr_in    (bus.regWr_in),
    .wsel_in     (bus.wsel_in),
    .memToReg_in (bus.memToReg_in),
    .halt_in     (bus.halt_in),
    .dmemload_in (bus.dmemload_in),
    .portO_in    (bus.portO_in),
    .luiValue_in (bus.luiValue_in),
    .pc4_in      (bus.pc4_in),
`ifdef MEM_WB_PERF_EN
    .perf_retired(bus.perf_retired),
    .perf_bubbles(bus.perf_bubbles),
`endif
    .valid_out   (bus.valid_out),
    .WEN         (bus.WEN),
    .wsel_out    (bus.wsel_out),
    .wdat_out    (bus.wdat_out),
    .halt_out    (bus.halt_out)
  );

  initial bus.CLK = 1'b0;
  always #5 bus.CLK = ~bus.CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of the latch contents.
  bit        m_valid, m_regwr, m_halted;
  int        m_wsel, m_halt_edges, m_ret, m_bub;
  bit [31:0] m_wdat;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_regwr = 0; m_halted = 0; m_wsel = 0; m_wdat = 0;
    m_halt_edges = 0; m_ret = 0; m_bub = 0;
  endtask

  task automatic model_apply(in_t v);
    bit [31:0] cand [4];
    cand[0] = v.porto; cand[1] = v.dmem; cand[2] = v.lui; cand[3] = v.pc4;
    if (m_halted) begin
      m_halt_edges++;
    end else if (v.flush) begin
      m_valid = 0; m_regwr = 0; m_wsel = 0; m_wdat = 0;
      m_bub++;
    end else if ((v.ihit || v.dhit) && !v.stall) begin
      m_valid = v.valid; m_regwr = v.regwr; m_wsel = v.wsel;
      m_wdat  = cand[v.mts];
      if (v.valid) m_ret++; else m_bub++;
      if (v.valid && v.halt) begin
        m_halted = 1; m_halt_edges = 0;
      end
    end
  endtask

  function automatic bit model_wen();
    return m_valid && m_regwr && (m_wsel != 0) && !(m_halted && m_halt_edges > 0);
  endfunction

  task automatic drive(in_t v);
    bus.ihit = v.ihit; bus.dhit = v.dhit; bus.stall = v.stall; bus.flush = v.flush;
    bus.valid_in = v.valid; bus.regWr_in = v.regwr; bus.wsel_in = v.wsel;
    bus.memToReg_in = v.mts; bus.halt_in = v.halt;
    bus.dmemload_in = v.dmem; bus.portO_in = v.porto;
    bus.luiValue_in = v.lui; bus.pc4_in = v.pc4;
  endtask

  function automatic in_t idle_in();
    in_t v;
    v.ihit = 0; v.dhit = 0; v.stall = 0; v.flush = 0; v.valid = 0;
    v.regwr = 0; v.halt = 0; v.wsel = 0; v.mts = 0;
    v.dmem = 0; v.porto = 0; v.lui = 0; v.pc4 = 0;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.ihit  = ($urandom_range(0, 3) != 0);
    v.dhit  = $urandom_range(0, 1) != 0;
    v.stall = ($urandom_range(0, 3) == 0);
    v.flush = ($urandom_range(0, 7) == 0);
    v.valid = ($urandom_range(0, 4) != 0);
    v.regwr = $urandom_range(0, 1) != 0;
    v.halt  = ($urandom_range(0, 39) == 0);
    v.wsel  = 5'($urandom_range(0, 31));
    v.mts   = 2'($urandom_range(0, 3));
    v.dmem  = $urandom; v.porto = $urandom; v.lui = $urandom; v.pc4 = $urandom;
    return v;
  endfunction

  // Valid, non-halting register write with a random payload.
  function automatic in_t valid_write();
    in_t v;
    v = rand_in();
    v.ihit = 1; v.stall = 0; v.flush = 0; v.valid = 1; v.regwr = 1; v.halt = 0;
    v.wsel = 5'($urandom_range(1, 31));
    return v;
  endfunction

  // One clock: inputs applied away from the edge, model updated at the edge,
  // outputs sampled 1 time unit later.
  task automatic step(in_t v);
    drive(v);
    @(posedge bus.CLK);
    model_apply(v);
    #1;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".valid"}, bus.valid_out, m_valid);
    chk({tag, ".wen"},   bus.WEN, model_wen());
    chk({tag, ".wsel"},  bus.wsel_out, m_wsel);
    chk({tag, ".wdat"},  bus.wdat_out, m_wdat);
    chk({tag, ".halt"},  bus.halt_out, m_halted);
`ifdef MEM_WB_PERF_EN
    chk({tag, ".retired"}, bus.perf_retired, m_ret % (1 << CW));
    chk({tag, ".bubbles"}, bus.perf_bubbles, m_bub % (1 << CW));
`endif
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset(string tag);
    drive(idle_in());
    @(posedge bus.CLK);
    #2 bus.RST = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, bus.valid_out, 0);
    chk({tag, ".rst_wen"},   bus.WEN, 0);
    chk({tag, ".rst_wsel"},  bus.wsel_out, 0);
    chk({tag, ".rst_wdat"},  bus.wdat_out, 0);
    chk({tag, ".rst_halt"},  bus.halt_out, 0);
`ifdef MEM_WB_PERF_EN
    chk({tag, ".rst_retired"}, bus.perf_retired, 0);
    chk({tag, ".rst_bubbles"}, bus.perf_bubbles, 0);
`endif
    repeat (2) @(posedge bus.CLK);
    @(negedge bus.CLK);
    bus.RST = 1'b0;
    model_reset();
    @(posedge bus.CLK);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    in_t v;
    bus.RST = 1'b0;
    drive(idle_in());
    model_reset();

    // ---------------- directed vector table ----------------
    v = idle_in(); v.dhit = 1; v.valid = 1; v.regwr = 1; v.wsel = 5; v.mts = 1;
    v.dmem = 32'hDEADBEEF; v.porto = 32'h1111;
    vecs[0] = '{v, 1, 1, 0, 5'd5, 32'hDEADBEEF};
    v = idle_in(); v.dhit = 1; v.valid = 1; v.regwr = 1; v.wsel = 7; v.mts = 3;
    v.pc4 = 32'h104; v.dmem = 32'h2222;
    vecs[1] = '{v, 1, 1, 0, 5'd7, 32'h104};
    v = idle_in(); v.ihit = 1; v.valid = 1; v.regwr = 1; v.wsel = 0; v.mts = 0;
    v.porto = 32'h55;
    vecs[2] = '{v, 1, 0, 0, 5'd0, 32'h55};
    v = idle_in(); v.ihit = 1; v.stall = 1; v.valid = 1; v.regwr = 1; v.wsel = 9;
    v.mts = 2; v.lui = 32'h1234;
    vecs[3] = '{v, 1, 0, 0, 5'd0, 32'h55};
    v = idle_in(); v.dhit = 1; v.stall = 1; v.valid = 1; v.regwr = 1; v.wsel = 12;
    v.mts = 0; v.porto = 32'h9999;
    vecs[4] = '{v, 1, 0, 0, 5'd0, 32'h55};
    v = idle_in(); v.valid = 1; v.regwr = 1; v.wsel = 14; v.porto = 32'h7777;
    vecs[5] = '{v, 1, 0, 0, 5'd0, 32'h55};
    v = idle_in(); v.ihit = 1; v.stall = 1; v.flush = 1; v.valid = 1; v.regwr = 1;
    v.wsel = 3; v.porto = 32'hABAB;
    vecs[6] = '{v, 0, 0, 0, 5'd0, 32'h0};
    v = idle_in(); v.ihit = 1; v.valid = 1; v.regwr = 1; v.wsel = 31; v.mts = 2;
    v.lui = 32'hABCD0000;
    vecs[7] = '{v, 1, 1, 0, 5'd31, 32'hABCD0000};
    v = idle_in(); v.ihit = 1; v.flush = 1; v.valid = 1; v.halt = 1; v.regwr = 1;
    v.wsel = 2; v.porto = 32'h4242;
    vecs[8] = '{v, 0, 0, 0, 5'd0, 32'h0};
    v = idle_in(); v.dhit = 1; v.valid = 0; v.halt = 1; v.regwr = 1; v.wsel = 3;
    v.mts = 3; v.pc4 = 32'h200;
    vecs[9] = '{v, 0, 0, 0, 5'd3, 32'h200};

    #2 bus.RST = 1'b1;
    #1;
    chk("init.rst_valid", bus.valid_out, 0);
    chk("init.rst_wen",   bus.WEN, 0);
    chk("init.rst_wsel",  bus.wsel_out, 0);
    chk("init.rst_wdat",  bus.wdat_out, 0);
    chk("init.rst_halt",  bus.halt_out, 0);
    @(negedge bus.CLK);
    bus.RST = 1'b0;
    @(posedge bus.CLK);
    #1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].in);
      $display("vec %0d: valid=%0b WEN=%0b wsel=%0d wdat=%08h halt=%0b",
               i, bus.valid_out, bus.WEN, bus.wsel_out, bus.wdat_out, bus.halt_out);
      chk($sformatf("vec%0d.valid", i), bus.valid_out, vecs[i].e_valid);
      chk($sformatf("vec%0d.wen", i),   bus.WEN,       vecs[i].e_wen);
      chk($sformatf("vec%0d.wsel", i),  bus.wsel_out,  vecs[i].e_wsel);
      chk($sformatf("vec%0d.wdat", i),  bus.wdat_out,  vecs[i].e_wdat);
      chk($sformatf("vec%0d.halt", i),  bus.halt_out,  vecs[i].e_halt);
      check_model($sformatf("vec%0d.model", i));
    end

    // ---------------- halt with regWr=0, then frozen ----------------
    v = idle_in(); v.ihit = 1; v.valid = 1; v.halt = 1; v.regwr = 0; v.wsel = 4;
    v.porto = 32'h77;
    step(v);
    $display("halt0: halt=%0b WEN=%0b wdat=%08h", bus.halt_out, bus.WEN, bus.wdat_out);
    chk("halt0.halt", bus.halt_out, 1);
    chk("halt0.wen",  bus.WEN, 0);
    for (int i = 0; i < 5; i++) begin
      step(valid_write());
      $display("halt0 frozen %0d: WEN=%0b wsel=%0d wdat=%08h", i, bus.WEN, bus.wsel_out, bus.wdat_out);
      chk("frozen.wen",  bus.WEN, 0);
      chk("frozen.wsel", bus.wsel_out, 4);
      chk("frozen.wdat", bus.wdat_out, 32'h77);
      chk("frozen.halt", bus.halt_out, 1);
    end
    do_reset("halt0");

    // ---------------- halt with regWr=1: exactly one WEN pulse ----------------
    v = idle_in(); v.dhit = 1; v.valid = 1; v.halt = 1; v.regwr = 1; v.wsel = 6;
    v.mts = 1; v.dmem = 32'hCAFE;
    step(v);
    $display("halt1: halt=%0b WEN=%0b wsel=%0d", bus.halt_out, bus.WEN, bus.wsel_out);
    chk("halt1.wen_pulse", bus.WEN, 1);
    chk("halt1.halt",      bus.halt_out, 1);
    for (int i = 0; i < 3; i++) begin
      step(valid_write());
      $display("halt1 after %0d: WEN=%0b wdat=%08h", i, bus.WEN, bus.wdat_out);
      chk("halt1.wen_low", bus.WEN, 0);
      chk("halt1.wdat",    bus.wdat_out, 32'hCAFE);
    end
    do_reset("halt1");

`ifdef MEM_WB_PERF_EN
    // ---------------- counters: 10 valid + 2 bubbles ----------------
    for (int i = 0; i < 12; i++) begin
      v = valid_write();
      if (i == 4) v.valid = 0;
      if (i == 8) v.flush = 1;
      step(v);
    end
    $display("perf: retired=%0d bubbles=%0d", bus.perf_retired, bus.perf_bubbles);
    chk("perf10.retired", bus.perf_retired, 10);
    chk("perf10.bubbles", bus.perf_bubbles, 2);
    do_reset("perf10");
    for (int i = 0; i < 17; i++) step(valid_write());
    $display("perf wrap: retired=%0d", bus.perf_retired);
    chk("perf17.retired", bus.perf_retired, 1);
    chk("perf17.bubbles", bus.perf_bubbles, 0);
    do_reset("perf17");
`endif

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 400; i++) begin
      if (m_halted && m_halt_edges > 4) do_reset("rnd");
      step(rand_in());
      $display("rnd %0d: valid=%0b WEN=%0b wsel=%0d wdat=%08h halt=%0b",
               i, bus.valid_out, bus.WEN, bus.wsel_out, bus.wdat_out, bus.halt_out);
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
